// File: rtl/reg_wb_queue.sv
// Register-file write-back queue: buffers write requests, drives the single
// write port in FIFO order and forwards the newest pending value to two lookups.
module reg_wb_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_wn,
  input  logic [DW-1:0]            in_wd,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [AW-1:0]            WN,
  output logic [DW-1:0]            WD,
  input  logic [AW-1:0]            lk_rn1,
  output logic                     lk_hit1,
  output logic [DW-1:0]            lk_data1,
  input  logic [AW-1:0]            lk_rn2,
  output logic                     lk_hit2,
  output logic [DW-1:0]            lk_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned NP = 2;

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [AW-1:0] q_wn [DEPTH];
  logic [DW-1:0] q_wd [DEPTH];

  logic          push;
  logic          pop;
  logic [PW-1:0] idx;
  logic [AW-1:0] lk_rn_a   [NP];
  logic          lk_hit_a  [NP];
  logic [DW-1:0] lk_data_a [NP];

  // Accept/issue control; writes to register 0 are consumed but dropped
  always_comb begin
    in_ready = !reset && (count != CW'(DEPTH));
    push     = in_valid && in_ready && (in_wn != '0);
    pop      = (count != '0) && !wb_stall;
    RegWrite = pop;
    WN       = (count != '0) ? q_wn[head] : '0;
    WD       = (count != '0) ? q_wd[head] : '0;
  end

  // Queue storage and pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        q_wn[i] <= '0;
        q_wd[i] <= '0;
      end
    end else begin
      if (push) begin
        q_wn[tail] <= in_wn;
        q_wd[tail] <= in_wd;
        tail       <= tail + PW'(1);
      end
      if (pop) begin
        head <= head + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign lk_rn_a[0] = lk_rn1;
  assign lk_rn_a[1] = lk_rn2;

  // Walk entries oldest to youngest so the youngest match wins
  always_comb begin
    idx = '0;
    for (int unsigned p = 0; p < NP; p++) begin
      lk_hit_a[p]  = 1'b0;
      lk_data_a[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count) && (lk_rn_a[p] != '0) && (q_wn[idx] == lk_rn_a[p])) begin
          lk_hit_a[p]  = 1'b1;
          lk_data_a[p] = q_wd[idx];
        end
      end
    end
  end

  assign lk_hit1  = lk_hit_a[0];
  assign lk_data1 = lk_data_a[0];
  assign lk_hit2  = lk_hit_a[1];
  assign lk_data2 = lk_data_a[1];

endmodule

// File: tb/tb_reg_wb_queue.sv
// Randomized bench for reg_wb_queue against a queue-based reference model.
module tb_reg_wb_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_wn;
  logic [DW-1:0] in_wd;
  logic          wb_stall;
  logic          RegWrite;
  logic [AW-1:0] WN;
  logic [DW-1:0] WD;
  logic [AW-1:0] lk_rn1;
  logic          lk_hit1;
  logic [DW-1:0] lk_data1;
  logic [AW-1:0] lk_rn2;
  logic          lk_hit2;
  logic [DW-1:0] lk_data2;
  logic [2:0]    count;

  typedef struct packed {
    logic [AW-1:0] wn;
    logic [DW-1:0] wd;
  } ent_t;

  ent_t mq[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  reg_wb_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wn(in_wn), .in_wd(in_wd),
    .wb_stall(wb_stall), .RegWrite(RegWrite), .WN(WN), .WD(WD),
    .lk_rn1(lk_rn1), .lk_hit1(lk_hit1), .lk_data1(lk_data1),
    .lk_rn2(lk_rn2), .lk_hit2(lk_hit2), .lk_data2(lk_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Newest queued value for a register, searching from youngest entry
  task automatic model_lookup(input logic [AW-1:0] rn, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (rn != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].wn == rn) begin
          hit  = 1'b1;
          data = mq[i].wd;
          break;
        end
      end
    end
  endtask

  // One clock cycle: apply inputs, check outputs mid-cycle, advance model at the edge
  task automatic step(input logic v, input logic [AW-1:0] wn, input logic [DW-1:0] wd,
                      input logic st, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic          e_ready, e_rw, h1, h2;
    logic [AW-1:0] e_wn;
    logic [DW-1:0] e_wd, d1, d2;
    in_valid = v; in_wn = wn; in_wd = wd; wb_stall = st; lk_rn1 = r1; lk_rn2 = r2;
    @(negedge clk);
    e_ready = (mq.size() != DEPTH);
    e_rw    = (mq.size() != 0) && !st;
    e_wn    = (mq.size() != 0) ? mq[0].wn : '0;
    e_wd    = (mq.size() != 0) ? mq[0].wd : '0;
    model_lookup(r1, h1, d1);
    model_lookup(r2, h2, d2);
    check("in_ready", 64'(in_ready), 64'(e_ready));
    check("RegWrite", 64'(RegWrite), 64'(e_rw));
    check("WN", 64'(WN), 64'(e_wn));
    check("WD", 64'(WD), 64'(e_wd));
    check("count", 64'(count), 64'(mq.size()));
    check("lk_hit1", 64'(lk_hit1), 64'(h1));
    check("lk_data1", 64'(lk_data1), 64'(d1));
    check("lk_hit2", 64'(lk_hit2), 64'(h2));
    check("lk_data2", 64'(lk_data2), 64'(d2));
    @(posedge clk);
    if (e_rw) mq.delete(0);
    if (v && e_ready && wn != '0) mq.push_back('{wn: wn, wd: wd});
    #1;
  endtask

  task automatic idle(input logic st);
    step(1'b0, '0, '0, st, '0, '0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_wn = '0; in_wd = '0;
    wb_stall = 1'b0; lk_rn1 = '0; lk_rn2 = '0;
    #1 reset = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_regwrite", 64'(RegWrite), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_lk_hit1", 64'(lk_hit1), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Single write then drain
    step(1'b1, 5'd5, 32'h0000_00AA, 1'b0, 5'd5, 5'd0);
    step(1'b0, '0, '0, 1'b0, 5'd5, 5'd0);
    idle(1'b0);

    // Register 0 write is consumed but never issued
    step(1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 5'd0);
    step(1'b0, '0, '0, 1'b0, 5'd0, 5'd0);
    idle(1'b0);

    // Fill under stall, same register four times, then drain
    for (int i = 1; i <= 4; i++) step(1'b1, 5'd3, DW'(i), 1'b1, 5'd3, 5'd3);
    step(1'b1, 5'd9, 32'hDEAD, 1'b1, 5'd3, 5'd9);
    for (int i = 0; i < 5; i++) step(1'b0, '0, '0, 1'b0, 5'd3, 5'd3);

    // Wrap-around with stall toggling and a repeated register
    for (int i = 0; i < 6; i++)
      step(1'b1, (i == 1 || i == 4) ? 5'd7 : AW'(10 + i), DW'(32'h100 + i), 1'(i % 2), 5'd7, 5'd7);
    step(1'b0, '0, '0, 1'b1, 5'd7, 5'd7);
    for (int i = 0; i < 4; i++) step(1'b1, AW'(20 + i), DW'(32'h200 + i), 1'b0, 5'd7, 5'd20);
    for (int i = 0; i < 6; i++) idle(1'b0);

    // Randomized traffic on a small register set to exercise forwarding
    for (int i = 0; i < 2000; i++) begin
      step(1'($urandom_range(0, 9) < 7), AW'($urandom_range(0, 7)), DW'($urandom()),
           1'($urandom_range(0, 9) < 3), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    for (int i = 0; i < 8; i++) idle(1'b0);

    // Asynchronous reset between edges with three entries pending
    for (int i = 0; i < 3; i++) step(1'b1, AW'(4 + i), DW'(32'h300 + i), 1'b1, 5'd4, 5'd6);
    in_valid = 1'b0; wb_stall = 1'b0; lk_rn1 = 5'd4; lk_rn2 = 5'd6;
    @(negedge clk);
    check("pre_rst_regwrite", 64'(RegWrite), 64'd1);
    check("pre_rst_count", 64'(count), 64'd3);
    #2 reset = 1'b1;
    #1;
    check("arst_regwrite", 64'(RegWrite), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_lk_hit1", 64'(lk_hit1), 64'd0);
    check("arst_lk_hit2", 64'(lk_hit2), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd0);
    check("arst_WN", 64'(WN), 64'd0);
    mq.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b0, 5'd4, 5'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
